// File: rtl/maze_pkg.sv
// Shared definitions for the maze game screen pipeline.
//   game_state_e : screen state encoding (BANNER=0, PLAY=1, WIN=2, GAME_OVER=3)
//   colour constants : 24-bit {R,G,B} values used by the compositor colour mux
//   HUD_ROWS     : raster lines at the top of the screen reserved for the level HUD
package maze_pkg;

  typedef enum logic [1:0] {
    ST_BANNER    = 2'd0,
    ST_PLAY      = 2'd1,
    ST_WIN       = 2'd2,
    ST_GAME_OVER = 2'd3
  } game_state_e;

  localparam logic [23:0] TEXT_WHITE = 24'hFFFFFF;
  localparam logic [23:0] PLAYER     = 24'hFFD700;
  localparam logic [23:0] GOAL       = 24'hFF00FF;
  localparam logic [23:0] WALL       = 24'h0000FF;
  localparam logic [23:0] WALL_DIM   = 24'h000060;
  localparam logic [23:0] BACKGROUND = 24'h101010;
  localparam logic [23:0] WIN_GREEN  = 24'h00FF00;
  localparam logic [23:0] LOSE_RED   = 24'hFF0000;

  localparam int HUD_ROWS = 20;

endpackage

// File: rtl/frame_timer.sv
// Frame pacing for the screen compositor.
//   clk, rst   : pixel clock, asynchronous active-low reset
//   vsync_in   : active-low vertical sync from the timing generator
//   blink_adv  : advance the blink phase by one frame (only sampled on frame_tick frames)
//   blink_clr  : return the blink phase to its start (text visible)
//   frame_tick : one-cycle pulse, registered, on each falling edge of vsync_in
//   blink_on   : high during the first BLINK_FRAMES frames of each 2*BLINK_FRAMES period
module frame_timer
  import maze_pkg::*;
#(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync_in,
  input  logic blink_adv,
  input  logic blink_clr,
  output logic frame_tick,
  output logic blink_on
);

  localparam int                  BLINK_W    = $clog2(2 * BLINK_FRAMES);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(2 * BLINK_FRAMES - 1);
  localparam logic [BLINK_W-1:0] BLINK_HALF = BLINK_W'(BLINK_FRAMES);

  logic               vsync_q, vsync_d;
  logic               tick_q, tick_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;

  always_comb begin
    vsync_d     = vsync_in;
    // Sync idles high, so a high-to-low step marks the start of a new frame.
    tick_d      = vsync_q & ~vsync_in;
    blink_cnt_d = blink_cnt_q;
    if (blink_clr) begin
      blink_cnt_d = '0;
    end else if (blink_adv) begin
      blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + BLINK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_q     <= 1'b1;
      tick_q      <= 1'b0;
      blink_cnt_q <= '0;
    end else begin
      vsync_q     <= vsync_d;
      tick_q      <= tick_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign frame_tick = tick_q;
  assign blink_on   = (blink_cnt_q < BLINK_HALF);

endmodule

// File: rtl/screen_compositor.sv
// Final pixel stage of the maze game: screen sequencing plus colour compositing.
//   clk, rst                 : pixel clock, asynchronous active-low reset
//   xCount, yCount           : raster position; video_on/hsync_in/vsync_in share its timing
//   *_text, maze_wall, player_pix, goal_pix : pixel masks, one cycle behind xCount
//   player_hit, goal_reached, restart       : one-cycle game event pulses
//   red, green, blue         : registered colour, two cycles behind xCount
//   hsync_out, vsync_out     : syncs delayed to match the colour output
//   level, game_state        : current level (1..NUM_LEVELS) and screen state
//   move_enable              : high only while the game is in PLAY
module screen_compositor
  import maze_pkg::*;
#(
  parameter int BANNER_FRAMES = 120,
  parameter int BLINK_FRAMES  = 30,
  parameter int NUM_LEVELS    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] xCount,
  input  logic [9:0] yCount,
  input  logic       video_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       game_over_text,
  input  logic       win_text,
  input  logic       level_text,
  input  logic       level_num1_text,
  input  logic       level_num2_text,
  input  logic       maze_wall,
  input  logic       player_pix,
  input  logic       goal_pix,
  input  logic       player_hit,
  input  logic       goal_reached,
  input  logic       restart,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [1:0] level,
  output logic [2:0] game_state,
  output logic       move_enable
);

  localparam int                   BANNER_W    = (BANNER_FRAMES > 1) ? $clog2(BANNER_FRAMES) : 1;
  localparam logic [BANNER_W-1:0] BANNER_LAST = BANNER_W'(BANNER_FRAMES - 1);
  localparam logic [1:0]          LAST_LEVEL  = 2'(NUM_LEVELS);

  // The masks already encode horizontal position, so xCount carries no extra information here.
  logic unused_xcount;
  assign unused_xcount = ^xCount;

  logic frame_tick, blink_on, blink_adv, blink_clr;

  game_state_e          state_q, state_d;
  logic [1:0]           level_q, level_d;
  logic [BANNER_W-1:0]  banner_cnt_q, banner_cnt_d;
  logic                 hit_pend_q, hit_pend_d;
  logic                 goal_pend_q, goal_pend_d;
  logic                 restart_pend_q, restart_pend_d;
  logic                 move_enable_q, move_enable_d;

  logic                 vld_p1_q, vld_p1_d;
  logic                 hud_p1_q, hud_p1_d;
  logic                 hsync_p1_q, hsync_p1_d;
  logic                 vsync_p1_q, vsync_p1_d;
  logic [23:0]          rgb_p2_q, rgb_p2_d;
  logic                 hsync_p2_q, hsync_p2_d;
  logic                 vsync_p2_q, vsync_p2_d;
  logic                 num_text;

  // Blink phase only runs on the end screens; a consumed restart rewinds it.
  assign blink_adv = frame_tick & ~restart_pend_q &
                     ((state_q == ST_WIN) || (state_q == ST_GAME_OVER));
  assign blink_clr = frame_tick & restart_pend_q;

  frame_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_frame_timer (
    .clk        (clk),
    .rst        (rst),
    .vsync_in   (vsync_in),
    .blink_adv  (blink_adv),
    .blink_clr  (blink_clr),
    .frame_tick (frame_tick),
    .blink_on   (blink_on)
  );

  // Screen FSM: events are latched as pending and only acted on at frame boundaries,
  // so the picture never switches mid-frame.
  always_comb begin
    state_d        = state_q;
    level_d        = level_q;
    banner_cnt_d   = banner_cnt_q;
    hit_pend_d     = hit_pend_q | player_hit;
    goal_pend_d    = goal_pend_q | goal_reached;
    restart_pend_d = restart_pend_q | restart;
    move_enable_d  = (state_q == ST_PLAY);

    if (frame_tick) begin
      // Pulses landing on the tick cycle itself belong to the next frame.
      hit_pend_d     = player_hit;
      goal_pend_d    = goal_reached;
      restart_pend_d = restart;

      if (restart_pend_q) begin
        state_d      = ST_BANNER;
        level_d      = 2'd1;
        banner_cnt_d = '0;
      end else begin
        case (state_q)
          ST_BANNER: begin
            if (banner_cnt_q == BANNER_LAST) begin
              state_d      = ST_PLAY;
              banner_cnt_d = '0;
            end else begin
              banner_cnt_d = banner_cnt_q + BANNER_W'(1);
            end
          end
          ST_PLAY: begin
            if (hit_pend_q) begin
              state_d = ST_GAME_OVER;
            end else if (goal_pend_q) begin
              if (level_q < LAST_LEVEL) begin
                level_d = level_q + 2'd1;
                state_d = ST_BANNER;
              end else begin
                state_d = ST_WIN;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Stage 1: align video_on, syncs and the HUD row flag with the one-cycle-late masks.
  always_comb begin
    vld_p1_d   = video_on;
    hud_p1_d   = (yCount < 10'(HUD_ROWS));
    hsync_p1_d = hsync_in;
    vsync_p1_d = vsync_in;
  end

  // Stage 2: colour mux, first matching rule wins.
  always_comb begin
    num_text   = (level_q == 2'd1) ? level_num1_text : level_num2_text;
    rgb_p2_d   = '0;
    hsync_p2_d = hsync_p1_q;
    vsync_p2_d = vsync_p1_q;
    if (vld_p1_q) begin
      case (state_q)
        ST_BANNER: begin
          if (level_text || num_text) rgb_p2_d = TEXT_WHITE;
        end
        ST_PLAY: begin
          if ((level_text || num_text) && hud_p1_q) rgb_p2_d = TEXT_WHITE;
          else if (player_pix)                      rgb_p2_d = PLAYER;
          else if (goal_pix)                        rgb_p2_d = GOAL;
          else if (maze_wall)                       rgb_p2_d = WALL;
          else                                      rgb_p2_d = BACKGROUND;
        end
        ST_WIN: begin
          if (win_text && blink_on) rgb_p2_d = WIN_GREEN;
        end
        ST_GAME_OVER: begin
          if (game_over_text && blink_on) rgb_p2_d = LOSE_RED;
          else if (maze_wall)             rgb_p2_d = WALL_DIM;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_BANNER;
      level_q        <= 2'd1;
      banner_cnt_q   <= '0;
      hit_pend_q     <= 1'b0;
      goal_pend_q    <= 1'b0;
      restart_pend_q <= 1'b0;
      move_enable_q  <= 1'b0;
      vld_p1_q       <= 1'b0;
      hud_p1_q       <= 1'b0;
      hsync_p1_q     <= 1'b1;
      vsync_p1_q     <= 1'b1;
      rgb_p2_q       <= '0;
      hsync_p2_q     <= 1'b1;
      vsync_p2_q     <= 1'b1;
    end else begin
      state_q        <= state_d;
      level_q        <= level_d;
      banner_cnt_q   <= banner_cnt_d;
      hit_pend_q     <= hit_pend_d;
      goal_pend_q    <= goal_pend_d;
      restart_pend_q <= restart_pend_d;
      move_enable_q  <= move_enable_d;
      vld_p1_q       <= vld_p1_d;
      hud_p1_q       <= hud_p1_d;
      hsync_p1_q     <= hsync_p1_d;
      vsync_p1_q     <= vsync_p1_d;
      rgb_p2_q       <= rgb_p2_d;
      hsync_p2_q     <= hsync_p2_d;
      vsync_p2_q     <= vsync_p2_d;
    end
  end

  assign red         = rgb_p2_q[23:16];
  assign green       = rgb_p2_q[15:8];
  assign blue        = rgb_p2_q[7:0];
  assign hsync_out   = hsync_p2_q;
  assign vsync_out   = vsync_p2_q;
  assign level       = level_q;
  assign game_state  = {1'b0, state_q};
  assign move_enable = move_enable_q;

endmodule

// File: tb/tb_screen_compositor.sv
// Bench for screen_compositor on a compact raster (8 pixels x 120 lines per frame,
// 6x110 visible, hsync low at x=6, vsync low on lines 112-113).
module tb_screen_compositor;

  localparam int HTOT = 8;
  localparam int HVIS = 6;
  localparam int VTOT = 120;
  localparam int VVIS = 110;
  localparam int BF   = 4;
  localparam int BLF  = 2;

  localparam logic [23:0] C_WHITE  = 24'hFFFFFF;
  localparam logic [23:0] C_PLAYER = 24'hFFD700;
  localparam logic [23:0] C_GOAL   = 24'hFF00FF;
  localparam logic [23:0] C_WALL   = 24'h0000FF;
  localparam logic [23:0] C_DIM    = 24'h000060;
  localparam logic [23:0] C_BG     = 24'h101010;
  localparam logic [23:0] C_GREEN  = 24'h00FF00;
  localparam logic [23:0] C_RED    = 24'hFF0000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] xCount = '0;
  logic [9:0] yCount = '0;
  logic       video_on = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
  logic       game_over_text = 1'b0, win_text = 1'b0, level_text = 1'b0;
  logic       level_num1_text = 1'b0, level_num2_text = 1'b0;
  logic       maze_wall = 1'b0, player_pix = 1'b0, goal_pix = 1'b0;
  logic       player_hit = 1'b0, goal_reached = 1'b0, restart = 1'b0;
  logic [7:0] red, green, blue;
  logic       hsync_out, vsync_out, move_enable;
  logic [1:0] level;
  logic [2:0] game_state;

  always #5 clk = ~clk;

  screen_compositor #(
    .BANNER_FRAMES(BF),
    .BLINK_FRAMES (BLF),
    .NUM_LEVELS   (2)
  ) dut (
    .clk(clk), .rst(rst), .xCount(xCount), .yCount(yCount), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .game_over_text(game_over_text),
    .win_text(win_text), .level_text(level_text), .level_num1_text(level_num1_text),
    .level_num2_text(level_num2_text), .maze_wall(maze_wall), .player_pix(player_pix),
    .goal_pix(goal_pix), .player_hit(player_hit), .goal_reached(goal_reached),
    .restart(restart), .red(red), .green(green), .blue(blue), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .level(level), .game_state(game_state), .move_enable(move_enable)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int          m_state = 0, m_level = 1, m_banner = 0, m_blink = 0;
  bit          pend_hit = 0, pend_goal = 0, pend_rs = 0;
  bit          vs_h1 = 1, vs_h2 = 1, hs_h1 = 1, vid_h1 = 0;
  int          y_h1 = 0;
  logic [23:0] e_rgb = '0;
  bit          e_hs = 1, e_vs = 1, e_me = 0;
  int          e_state = 0, e_level = 1;

  // Colour the screen must show for a pixel, from the game rules.
  function automatic logic [23:0] exp_colour(input bit vid, input int y, input int st,
                                             input int lvl, input int blink);
    bit num_t;
    bit shown;
    num_t = (lvl == 1) ? level_num1_text : level_num2_text;
    shown = (blink < BLF);
    if (!vid) return 24'h0;
    case (st)
      0: return (level_text || num_t) ? C_WHITE : 24'h0;
      1: begin
        if ((level_text || num_t) && y < 20) return C_WHITE;
        if (player_pix) return C_PLAYER;
        if (goal_pix)   return C_GOAL;
        if (maze_wall)  return C_WALL;
        return C_BG;
      end
      2: return (win_text && shown) ? C_GREEN : 24'h0;
      default: begin
        if (game_over_text && shown) return C_RED;
        if (maze_wall) return C_DIM;
        return 24'h0;
      end
    endcase
  endfunction

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_state = 0; m_level = 1; m_banner = 0; m_blink = 0;
      pend_hit = 0; pend_goal = 0; pend_rs = 0;
      vs_h1 = 1; vs_h2 = 1; hs_h1 = 1; vid_h1 = 0; y_h1 = 0;
      e_rgb = '0; e_hs = 1; e_vs = 1; e_me = 0; e_state = 0; e_level = 1;
    end else begin
      // pixel path: colour and syncs two cycles behind the raster position
      e_rgb = exp_colour(vid_h1, y_h1, m_state, m_level, m_blink);
      e_hs  = hs_h1;
      e_vs  = vs_h1;
      e_me  = (m_state == 1);
      // frame boundary: one cycle after vsync was seen falling
      if (vs_h2 && !vs_h1) begin
        if (pend_rs) begin
          m_state = 0; m_level = 1; m_banner = 0; m_blink = 0;
        end else begin
          case (m_state)
            0: if (m_banner == BF - 1) begin m_state = 1; m_banner = 0; end
               else m_banner++;
            1: if (pend_hit) m_state = 3;
               else if (pend_goal) begin
                 if (m_level < 2) begin m_level++; m_state = 0; end
                 else m_state = 2;
               end
            default: m_blink = (m_blink + 1) % (2 * BLF);
          endcase
        end
        pend_hit = player_hit; pend_goal = goal_reached; pend_rs = restart;
      end else begin
        pend_hit  = pend_hit  | player_hit;
        pend_goal = pend_goal | goal_reached;
        pend_rs   = pend_rs   | restart;
      end
      e_state = m_state;
      e_level = m_level;
      vs_h2 = vs_h1; vs_h1 = vsync_in; hs_h1 = hsync_in; vid_h1 = video_on; y_h1 = yCount;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("cyc_rgb",   32'({red, green, blue}), 32'(e_rgb));
    chk("cyc_hsync", 32'(hsync_out),          32'(e_hs));
    chk("cyc_vsync", 32'(vsync_out),          32'(e_vs));
    chk("cyc_move",  32'(move_enable),        32'(e_me));
    chk("cyc_state", 32'(game_state),         32'(e_state));
    chk("cyc_level", 32'(level),              32'(e_level));
  end

  // ---------------- raster driver ----------------
  int px = 0, py = 0, lx = -1, ly = -1;

  task automatic step(input bit hit = 1'b0, input bit goal = 1'b0, input bit rs = 1'b0);
    xCount          = 10'(px);
    yCount          = 10'(py);
    video_on        = (px < HVIS) && (py < VVIS);
    hsync_in        = !(px == 6);
    vsync_in        = !(py == 112 || py == 113);
    level_text      = (lx == 1) && (ly == 2 || ly == 30);
    level_num1_text = (lx == 2) && (ly == 2);
    level_num2_text = (lx == 3) && (ly == 2);
    win_text        = (lx == 1) && (ly == 50);
    game_over_text  = (lx == 2) && (ly == 50);
    maze_wall       = (lx == 0) || (ly == 60) || (lx == 3 && ly == 70) || (lx == 4 && ly == 50);
    player_pix      = (lx == 3) && (ly == 70);
    goal_pix        = (lx == 4) && (ly == 70);
    player_hit      = hit;
    goal_reached    = goal;
    restart         = rs;
    @(posedge clk);
    #1;
    lx = px; ly = py;
    px++;
    if (px == HTOT) begin px = 0; py = (py + 1) % VTOT; end
  endtask

  // Drive until the next position to be presented is (tx,ty).
  task automatic run_until(input int tx, input int ty);
    int n = 0;
    do begin step(); n++; end while (!(px == tx && py == ty) && n < 2000);
    if (!(px == tx && py == ty)) begin
      n_chk++;
      $display("FAIL run_until: got position %0d,%0d, required %0d,%0d", px, py, tx, ty);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(game_state), 32'd0);
    chk({tag, "_level"}, 32'(level), 32'd1);
    chk({tag, "_rgb"},   32'({red, green, blue}), 32'd0);
    chk({tag, "_hs"},    32'(hsync_out), 32'd1);
    chk({tag, "_vs"},    32'(vsync_out), 32'd1);
    chk({tag, "_me"},    32'(move_enable), 32'd0);
  endtask

  initial begin
    // 1: reset, banner, then PLAY on the fourth frame boundary
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b1;
    repeat (3) run_until(4, 112);
    chk("banner_hold", 32'(game_state), 32'd0);
    run_until(4, 112);
    chk("enter_play", 32'(game_state), 32'd1);
    chk("move_en_on", 32'(move_enable), 32'd1);

    // 2: goal mid-frame takes effect only at the next frame boundary
    run_until(0, 100);
    step(.goal(1'b1));
    run_until(0, 105);
    chk("goal_deferred", 32'(game_state), 32'd1);
    run_until(4, 112);
    chk("lvl2_banner_state", 32'(game_state), 32'd0);
    chk("lvl2_level", 32'(level), 32'd2);
    chk("move_en_off", 32'(move_enable), 32'd0);
    run_until(4, 2);
    chk("banner_num1_dark", 32'({red, green, blue}), 32'h0);
    run_until(5, 2);
    chk("banner_num2_white", 32'({red, green, blue}), 32'(C_WHITE));
    repeat (4) run_until(4, 112);
    chk("lvl2_play", 32'(game_state), 32'd1);

    // 3: hit and goal in one frame -> GAME_OVER, text blinks 2 on / 2 off
    run_until(0, 40);
    step(.hit(1'b1));
    run_until(0, 60);
    step(.goal(1'b1));
    run_until(4, 112);
    chk("game_over", 32'(game_state), 32'd3);
    for (int i = 0; i < 5; i++) begin
      run_until(4, 50);
      chk("go_blink", 32'({red, green, blue}), (i == 2 || i == 3) ? 32'h0 : 32'(C_RED));
    end
    step(.rs(1'b1));
    run_until(4, 112);
    chk("restart_state", 32'(game_state), 32'd0);
    chk("restart_level", 32'(level), 32'd1);

    // 5: pixel priority and two-cycle alignment in level 1 PLAY
    repeat (4) run_until(4, 112);
    chk("l1_play", 32'(game_state), 32'd1);
    run_until(4, 70);
    chk("pix_bg", 32'({red, green, blue}), 32'(C_BG));
    run_until(5, 70);
    chk("pix_player_over_wall", 32'({red, green, blue}), 32'(C_PLAYER));
    run_until(6, 70);
    chk("pix_goal", 32'({red, green, blue}), 32'(C_GOAL));
    run_until(7, 70);
    chk("hsync_one_stage", 32'(hsync_out), 32'd1);
    run_until(0, 71);
    chk("hsync_two_stage", 32'(hsync_out), 32'd0);

    // 4: finish level 1, then level 2 goal -> WIN
    step(.goal(1'b1));
    run_until(4, 112);
    chk("l2_banner", 32'(level), 32'd2);
    repeat (4) run_until(4, 112);
    run_until(3, 2);
    chk("hud_text", 32'({red, green, blue}), 32'(C_WHITE));
    run_until(3, 30);
    chk("below_hud", 32'({red, green, blue}), 32'(C_BG));
    run_until(0, 80);
    step(.goal(1'b1));
    run_until(4, 112);
    chk("win_state", 32'(game_state), 32'd2);
    run_until(3, 50);
    chk("win_text", 32'({red, green, blue}), 32'(C_GREEN));

    // 6: asynchronous reset mid-frame in WIN
    run_until(3, 40);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    repeat (3) step();
    rst = 1'b1;
    run_until(4, 112);
    chk("post_rst_banner", 32'(game_state), 32'd0);
    chk("post_rst_level", 32'(level), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
